weight_loader: RTL

WEIGHT_LOADER -- requirements
Module: weight_loader

---
 rtl/weight_loader.sv | 120 ++++++++++++
 1 files changed

// File: rtl/weight_loader.sv
// Weight loader: unpacks two-lane beats into single-word writes on the PE weight bus.
// Optional running checksum of written words enabled by WEIGHT_LOADER_CHECKSUM_EN.
module weight_loader #(
    parameter int unsigned     DATA_WIDTH  = 16,
    parameter logic [31:0]     BASE_ADDR   = 32'd0,
    parameter longint unsigned NUM_WEIGHTS = 4096
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic [2*DATA_WIDTH-1:0] i_data,
    input  logic                    i_valid,
    output logic                    i_ready,
    output logic [DATA_WIDTH-1:0]   weight_data,
    output logic [31:0]             weight_addr,
    output logic                    weight_we,
    output logic                    busy,
    output logic                    done,
    output logic [31:0]             checksum
);

    localparam logic [31:0] LAST_IDX  = 32'(NUM_WEIGHTS - 1);
    localparam logic [31:0] NUM_BEATS = 32'((NUM_WEIGHTS + 1) / 2);

    typedef enum logic {IDLE, LOAD} state_t;
    state_t state, state_nxt;

    logic [2*DATA_WIDTH-1:0] hold;
    logic                    hold_vld;
    logic                    lane;
    logic [31:0]             idx;
    logic [31:0]             beats;
    logic                    fin;

    logic                  emit;
    logic                  rel;
    logic                  accept;
    logic [DATA_WIDTH-1:0] cur;

    assign emit    = (state == LOAD) && hold_vld;
    assign cur     = lane ? hold[2*DATA_WIDTH-1:DATA_WIDTH] : hold[DATA_WIDTH-1:0];
    // Odd counts drop lane 1 of the final beat by releasing after the last index.
    assign rel     = lane || (idx == LAST_IDX);
    assign i_ready = (state == LOAD) && (beats < NUM_BEATS) && (!hold_vld || lane);
    assign accept  = i_valid && i_ready;
    assign busy    = (state == LOAD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = LOAD;
            LOAD: if (fin)   state_nxt = IDLE;
            default:         state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold        <= '0;
            hold_vld    <= 1'b0;
            lane        <= 1'b0;
            idx         <= '0;
            beats       <= '0;
            fin         <= 1'b0;
            weight_data <= '0;
            weight_addr <= '0;
            weight_we   <= 1'b0;
            done        <= 1'b0;
        end else begin
            weight_we <= emit;
            done      <= 1'b0;
            if (state == IDLE) begin
                if (start) begin
                    hold     <= '0;
                    hold_vld <= 1'b0;
                    lane     <= 1'b0;
                    idx      <= '0;
                    beats    <= '0;
                    fin      <= 1'b0;
                end
            end else begin
                if (emit) begin
                    weight_data <= cur;
                    weight_addr <= BASE_ADDR + idx;
                    idx         <= idx + 32'd1;
                    if (idx == LAST_IDX) fin <= 1'b1;
                    if (rel) hold_vld <= 1'b0;
                    else     lane     <= 1'b1;
                end
                // A new beat lands on the same edge lane 1 of the previous one is emitted.
                if (accept) begin
                    hold     <= i_data;
                    hold_vld <= 1'b1;
                    lane     <= 1'b0;
                    beats    <= beats + 32'd1;
                end
                if (fin) begin
                    done <= 1'b1;
                    fin  <= 1'b0;
                end
            end
        end
    end

`ifdef WEIGHT_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                      checksum <= '0;
        else if (state == IDLE && start) checksum <= '0;
        else if (emit)                   checksum <= checksum + 32'(cur);
    end
`else
    assign checksum = '0;
`endif

endmodule
